// File: rtl/drv_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : drv_pwr_seq
// Description : Per-drive-bay power sequencer. Enables the bay hot-swap
//               controller, qualifies its power-good against a ramp timeout
//               and then raises DRV_PWROK for the PCIe reset controller. On
//               power-down DRV_PWROK falls first so PERST# asserts before the
//               rail goes away, and a minimum off time is enforced before the
//               bay may be re-enabled.
// Ports       : SYSCLK      - system clock
//               RESET_N     - asynchronous active-low reset
//               DRV_PRSNT_L - bay presence, low = present (asynchronous)
//               PWR_REQ     - bay power request, high = on (asynchronous)
//               PWR_GOOD    - hot-swap power-good (asynchronous)
//               FAULT_CLR   - single-cycle fault clear (SYSCLK domain)
//               DRV_PWR_EN  - hot-swap enable
//               DRV_PWROK   - rails stable, to PCIe reset controller
//               PWR_FAULT   - latched power fault
//               STATE       - current state encoding for readback
// Revision    : 1.0 - initial release
// ============================================================================
module drv_pwr_seq #(
  parameter int CNT_W        = 32,
  parameter int RAMP_TIMEOUT = 2500000,
  parameter int DEBOUNCE     = 250,
  parameter int PERST_LEAD   = 25000,
  parameter int OFF_MIN      = 12500000
) (
  input  logic       SYSCLK,
  input  logic       RESET_N,
  input  logic       DRV_PRSNT_L,
  input  logic       PWR_REQ,
  input  logic       PWR_GOOD,
  input  logic       FAULT_CLR,
  output logic       DRV_PWR_EN,
  output logic       DRV_PWROK,
  output logic       PWR_FAULT,
  output logic [2:0] STATE
);

  // Reject parameter sets the counters cannot represent.
  generate
    if ((DEBOUNCE < 1) || ((DEBOUNCE >> CNT_W) != 0) ||
        (PERST_LEAD < 1) || ((PERST_LEAD >> CNT_W) != 0) ||
        (OFF_MIN < 1) || ((OFF_MIN >> CNT_W) != 0) ||
        (RAMP_TIMEOUT < 1) || ((RAMP_TIMEOUT >> CNT_W) != 0)) begin : g_bad_param
      $error("drv_pwr_seq: DEBOUNCE, PERST_LEAD, OFF_MIN, RAMP_TIMEOUT must be >= 1 and < 2**CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_ramp_last  = CNT_W'(RAMP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_lead_last  = CNT_W'(PERST_LEAD - 1);
  localparam logic [CNT_W-1:0] c_off_last   = CNT_W'(OFF_MIN - 1);
  localparam logic [CNT_W-1:0] c_debounce   = CNT_W'(DEBOUNCE);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RAMP      = 3'd1,
    ST_ON        = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DISCHARGE = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_db;
  logic             r_prsnt_l_meta, r_prsnt_l_sync;
  logic             r_req_meta,     r_req_sync;
  logic             r_good_meta,    r_good_sync;
  logic             w_present;
  logic             w_db_ok;
  logic             w_counting;

  // Two-flop synchronisers, reset to the levels that keep the bay off.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_prsnt_l_meta <= 1'b1;
      r_prsnt_l_sync <= 1'b1;
      r_req_meta     <= 1'b0;
      r_req_sync     <= 1'b0;
      r_good_meta    <= 1'b0;
      r_good_sync    <= 1'b0;
    end else begin
      r_prsnt_l_meta <= DRV_PRSNT_L;
      r_prsnt_l_sync <= r_prsnt_l_meta;
      r_req_meta     <= PWR_REQ;
      r_req_sync     <= r_req_meta;
      r_good_meta    <= PWR_GOOD;
      r_good_sync    <= r_good_meta;
    end
  end

  assign w_present  = ~r_prsnt_l_sync;
  assign w_db_ok    = (r_db == c_debounce);
  assign w_counting = (r_state == ST_RAMP) || (r_state == ST_DRAIN) ||
                      (r_state == ST_DISCHARGE);

  // Debounce: run length of consecutive synced power-good highs, capped.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_db <= '0;
    end else if (!r_good_sync) begin
      r_db <= '0;
    end else if (!w_db_ok) begin
      r_db <= r_db + CNT_W'(1);
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase counter restarts on every state change and never wraps.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (w_counting && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_OFF: begin
        if (w_present && r_req_sync) w_state_nxt = ST_RAMP;
      end
      ST_RAMP: begin
        // Losing the request or the drive beats qualification; a
        // qualification landing on the timeout cycle still wins.
        if (!w_present || !r_req_sync) w_state_nxt = ST_DISCHARGE;
        else if (w_db_ok)              w_state_nxt = ST_ON;
        else if (r_cnt == c_ramp_last) w_state_nxt = ST_FAULT;
      end
      ST_ON: begin
        if (!w_present)       w_state_nxt = ST_DISCHARGE;
        else if (!r_good_sync) w_state_nxt = ST_FAULT;
        else if (!r_req_sync)  w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // PWROK is already low here, so a power-good drop is irrelevant.
        if (!w_present || (r_cnt == c_lead_last)) w_state_nxt = ST_DISCHARGE;
      end
      ST_DISCHARGE: begin
        if (r_cnt == c_off_last) w_state_nxt = ST_OFF;
      end
      ST_FAULT: begin
        if (FAULT_CLR) w_state_nxt = ST_DISCHARGE;
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  // Outputs decode the state register only.
  assign DRV_PWR_EN = (r_state == ST_RAMP) || (r_state == ST_ON) ||
                      (r_state == ST_DRAIN);
  assign DRV_PWROK  = (r_state == ST_ON);
  assign PWR_FAULT  = (r_state == ST_FAULT);
  assign STATE      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_drv_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_drv_pwr_seq
// Description : Self-checking bench for drv_pwr_seq. A phase/elapsed-time
//               reference model driven from the history of sampled inputs is
//               compared against the DUT on every falling clock edge; a
//               directed sequence pins sequencing latencies to literal values,
//               then randomized input activity follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drv_pwr_seq;

  localparam int RT  = 20;
  localparam int DEB = 3;
  localparam int PL  = 5;
  localparam int OM  = 8;

  logic       SYSCLK = 1'b0;
  logic       RESET_N;
  logic       DRV_PRSNT_L;
  logic       PWR_REQ;
  logic       PWR_GOOD;
  logic       FAULT_CLR;
  logic       DRV_PWR_EN;
  logic       DRV_PWROK;
  logic       PWR_FAULT;
  logic [2:0] STATE;

  int n_checks = 0;
  int n_fail   = 0;

  drv_pwr_seq #(
    .CNT_W       (32),
    .RAMP_TIMEOUT(RT),
    .DEBOUNCE    (DEB),
    .PERST_LEAD  (PL),
    .OFF_MIN     (OM)
  ) dut (
    .SYSCLK     (SYSCLK),
    .RESET_N    (RESET_N),
    .DRV_PRSNT_L(DRV_PRSNT_L),
    .PWR_REQ    (PWR_REQ),
    .PWR_GOOD   (PWR_GOOD),
    .FAULT_CLR  (FAULT_CLR),
    .DRV_PWR_EN (DRV_PWR_EN),
    .DRV_PWROK  (DRV_PWROK),
    .PWR_FAULT  (PWR_FAULT),
    .STATE      (STATE)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase numbers: 0 off, 1 ramp, 2 on, 3 drain, 4 discharge, 5 fault.
  // Inputs are seen two sampling edges late; history queues hold the last
  // two samples so element 0 is the value the sequencer acts on.
  int q_prs_l[$];
  int q_req[$];
  int q_good[$];
  int m_ph;     // current phase
  int m_t;      // edges spent in the current phase
  int m_run;    // consecutive acted-on power-good highs, capped at DEB
  int en_tab[6]    = '{0, 1, 1, 1, 0, 0};
  int pwrok_tab[6] = '{0, 0, 1, 0, 0, 0};
  int fault_tab[6] = '{0, 0, 0, 0, 0, 1};

  task automatic model_reset();
    q_prs_l = '{1, 1};
    q_req   = '{0, 0};
    q_good  = '{0, 0};
    m_ph  = 0;
    m_t   = 0;
    m_run = 0;
  endtask

  task automatic model_step();
    int present, req, good, nxt;
    present = (q_prs_l[0] == 0);
    req     = q_req[0];
    good    = q_good[0];
    nxt     = m_ph;
    case (m_ph)
      0: if (present && req) nxt = 1;
      1: begin
        if (!present || !req) nxt = 4;
        else if (m_run == DEB) nxt = 2;
        else if (m_t == RT - 1) nxt = 5;
      end
      2: begin
        if (!present) nxt = 4;
        else if (!good) nxt = 5;
        else if (!req) nxt = 3;
      end
      3: if (!present || m_t == PL - 1) nxt = 4;
      4: if (m_t == OM - 1) nxt = 0;
      5: if (FAULT_CLR === 1'b1) nxt = 4;
      default: nxt = 0;
    endcase
    if (nxt != m_ph) m_t = 0;
    else if (m_ph == 1 || m_ph == 3 || m_ph == 4) m_t++;
    m_run = good ? ((m_run < DEB) ? m_run + 1 : DEB) : 0;
    m_ph  = nxt;
    q_prs_l.push_back(int'(DRV_PRSNT_L)); void'(q_prs_l.pop_front());
    q_req.push_back(int'(PWR_REQ));       void'(q_req.pop_front());
    q_good.push_back(int'(PWR_GOOD));     void'(q_good.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge SYSCLK or negedge RESET_N);
      if (RESET_N !== 1'b1) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge SYSCLK);
      check("STATE", int'(STATE), m_ph);
      check("DRV_PWR_EN", int'(DRV_PWR_EN), en_tab[m_ph]);
      check("DRV_PWROK", int'(DRV_PWROK), pwrok_tab[m_ph]);
      check("PWR_FAULT", int'(PWR_FAULT), fault_tab[m_ph]);
    end
  end

  // Counts falling edges until STATE equals s, giving up after max.
  task automatic wait_state(input int s, input int max, output int n);
    n = 0;
    while (int'(STATE) != s && n < max) begin
      @(negedge SYSCLK);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    RESET_N     = 1'b0;
    DRV_PRSNT_L = 1'b1;
    PWR_REQ     = 1'b0;
    PWR_GOOD    = 1'b0;
    FAULT_CLR   = 1'b0;
    repeat (3) @(negedge SYSCLK);
    check("rst_state", int'(STATE), 0);
    check("rst_en", int'(DRV_PWR_EN), 0);
    check("rst_pwrok", int'(DRV_PWROK), 0);
    check("rst_fault", int'(PWR_FAULT), 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge SYSCLK);
    check("idle_off", int'(STATE), 0);

    // Power-up with power-good arriving four cycles into the ramp.
    DRV_PRSNT_L = 1'b0;
    PWR_REQ     = 1'b1;
    wait_state(1, 10, n);
    check("pu_ramp_edges", n, 3);
    check("ramp_en", int'(DRV_PWR_EN), 1);
    check("ramp_pwrok", int'(DRV_PWROK), 0);
    repeat (3) @(negedge SYSCLK);
    PWR_GOOD = 1'b1;
    wait_state(2, 20, n);
    check("pu_on_edges", n, 6);
    check("on_pwrok", int'(DRV_PWROK), 1);
    check("on_state", int'(STATE), 2);

    // Orderly off, then a re-request during discharge.
    PWR_REQ = 1'b0;
    wait_state(3, 10, n);
    check("drain_entry_edges", n, 3);
    check("drain_en", int'(DRV_PWR_EN), 1);
    check("drain_pwrok", int'(DRV_PWROK), 0);
    wait_state(4, 20, n);
    check("drain_len", n, PL);
    check("discharge_en", int'(DRV_PWR_EN), 0);
    PWR_REQ = 1'b1;
    wait_state(0, 20, n);
    check("discharge_len", n, OM);
    wait_state(1, 10, n);
    check("reseq_ramp_edges", n, 1);
    wait_state(2, 20, n);
    check("reseq_on_edges", n, 1);

    // Brownout in ON.
    PWR_GOOD = 1'b0;
    wait_state(5, 10, n);
    check("brownout_edges", n, 3);
    check("brownout_en", int'(DRV_PWR_EN), 0);
    check("brownout_pwrok", int'(DRV_PWROK), 0);
    check("brownout_fault", int'(PWR_FAULT), 1);
    PWR_REQ = 1'b0;
    repeat (4) @(negedge SYSCLK);
    check("fault_latched", int'(STATE), 5);
    FAULT_CLR = 1'b1;
    @(negedge SYSCLK);
    FAULT_CLR = 1'b0;
    check("clr_to_discharge", int'(STATE), 4);
    check("clr_fault_low", int'(PWR_FAULT), 0);
    wait_state(0, 20, n);
    check("clr_discharge_len", n, OM);

    // Ramp with a 2-cycle power-good glitch, then timeout.
    PWR_REQ = 1'b1;
    wait_state(1, 10, n);
    check("to_ramp_edges", n, 3);
    repeat (2) @(negedge SYSCLK);
    PWR_GOOD = 1'b1;
    repeat (2) @(negedge SYSCLK);
    PWR_GOOD = 1'b0;
    wait_state(5, 40, n);
    check("ramp_timeout_edges", n + 4, RT);
    check("timeout_en", int'(DRV_PWR_EN), 0);
    check("timeout_fault", int'(PWR_FAULT), 1);
    PWR_REQ   = 1'b0;
    FAULT_CLR = 1'b1;
    @(negedge SYSCLK);
    FAULT_CLR = 1'b0;
    wait_state(0, 20, n);
    check("timeout_discharge_len", n, OM);

    // Surprise removal from ON.
    PWR_REQ  = 1'b1;
    PWR_GOOD = 1'b1;
    wait_state(2, 40, n);
    check("reon_edges", n, 6);
    DRV_PRSNT_L = 1'b1;
    wait_state(4, 10, n);
    check("removal_edges", n, 3);
    check("removal_en", int'(DRV_PWR_EN), 0);
    check("removal_pwrok", int'(DRV_PWROK), 0);

    // Asynchronous reset while ON.
    DRV_PRSNT_L = 1'b0;
    wait_state(0, 20, n);
    wait_state(2, 40, n);
    check("pre_reset_on", int'(STATE), 2);
    repeat (2) @(negedge SYSCLK);
    #2 RESET_N = 1'b0;
    #1;
    check("areset_en", int'(DRV_PWR_EN), 0);
    check("areset_pwrok", int'(DRV_PWROK), 0);
    check("areset_state", int'(STATE), 0);
    @(negedge SYSCLK);
    #2 RESET_N = 1'b1;
    wait_state(1, 10, n);
    check("post_reset_ramp_edges", n, 3);
    wait_state(2, 20, n);
    check("post_reset_on_edges", n, 3);

    // Randomized activity.
    for (int i = 0; i < 4000; i++) begin
      @(negedge SYSCLK);
      if ($urandom_range(0, 199) == 0) DRV_PRSNT_L = ~DRV_PRSNT_L;
      if ($urandom_range(0, 59) == 0)  PWR_REQ     = ~PWR_REQ;
      if ($urandom_range(0, 19) == 0)  PWR_GOOD    = ~PWR_GOOD;
      FAULT_CLR = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2 RESET_N = 1'b0;
        #1;
        check("rand_areset_state", int'(STATE), 0);
        check("rand_areset_en", int'(DRV_PWR_EN), 0);
        @(negedge SYSCLK);
        #2 RESET_N = 1'b1;
      end
    end

    @(negedge SYSCLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
